// File: rtl/demux1to2_reg_if.sv
// demux1to2_reg_if: handshake bundle for the registered 1-to-2 demultiplexer.
//   in/in_valid/in_ready   : upstream word stream (ready is combinational)
//   sel/auto               : destination select, or follow the alternating pointer
//   outN/outN_valid/outN_ready : channel N output register and its consumer handshake
//   cnt0/cnt1              : per-channel delivered-word counters (wrap at 256)
//   ptr                    : alternating pointer state (0 = CH0, 1 = CH1)
// slave is the demux side, master is the upstream/consumer side.
interface demux1to2_reg_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic             in_ready;
   logic             sel;
   logic             auto;
   logic [WIDTH-1:0] out0;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1;
   logic             out1_valid;
   logic             out1_ready;
   logic [7:0]       cnt0;
   logic [7:0]       cnt1;
   logic             ptr;

   modport slave (
      input  in, in_valid, sel, auto, out0_ready, out1_ready,
      output in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1, ptr
   );

   modport master (
      output in, in_valid, sel, auto, out0_ready, out1_ready,
      input  in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1, ptr
   );
endinterface

// File: rtl/demux1to2_reg.sv
// demux1to2_reg: registered 1-to-2 demultiplexer with valid/ready handshakes.
// Steers each accepted input word into one of two one-entry output registers,
// chosen by sel or by an alternating pointer (auto = 1), and counts deliveries
// per channel.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : demux1to2_reg_if.slave (data, handshakes, sel/auto, counters, ptr)

// One output channel: data register, valid flag and delivered-word counter.
//   load  : accept a new word this cycle (has priority over drain)
//   ready : consumer handshake
module demux1to2_reg_ch #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic [7:0]       cnt
);
   logic drain;
   assign drain = valid & ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         dout  <= '0;
         valid <= 1'b0;
         cnt   <= '0;
      end else begin
         // Load wins over drain so a draining register can refill in one cycle;
         // on a plain drain the data is left in place.
         if (load) begin
            dout  <= din;
            valid <= 1'b1;
         end else if (drain) begin
            valid <= 1'b0;
         end
         if (drain)
            cnt <= cnt + 8'd1;
      end
   end
endmodule

module demux1to2_reg #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   demux1to2_reg_if.slave   bus
);
   typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} ptr_e;

   ptr_e                   state;
   logic                   ptr;
   logic                   dest;
   logic                   acc;
   logic [1:0]             vld;
   logic [1:0]             rdy;
   logic [1:0]             load;
   logic [1:0][WIDTH-1:0]  dout;
   logic [1:0][7:0]        cnt;

   assign ptr  = (state == CH1);
   assign dest = bus.auto ? ptr : bus.sel;
   assign rdy  = {bus.out1_ready, bus.out0_ready};

   // Only the destination channel gates acceptance; in_valid is kept out of
   // this path on purpose.
   assign bus.in_ready = ~vld[dest] | rdy[dest];
   assign acc          = bus.in_valid & bus.in_ready;
   assign load         = {acc & dest, acc & ~dest};

   // Alternating pointer: advances only on an accepted word in auto mode,
   // otherwise holds so auto can resume where it left off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CH0;
      end else if (acc & bus.auto) begin
         case (state)
            CH0:     state <= CH1;
            CH1:     state <= CH0;
            default: state <= CH0;
         endcase
      end
   end

   for (genvar n = 0; n < 2; n++) begin : g_ch
      demux1to2_reg_ch #(.WIDTH(WIDTH)) u_ch (
         .clk   (clk),
         .rst   (rst),
         .load  (load[n]),
         .din   (bus.in),
         .ready (rdy[n]),
         .dout  (dout[n]),
         .valid (vld[n]),
         .cnt   (cnt[n])
      );
   end

   assign bus.out0       = dout[0];
   assign bus.out0_valid = vld[0];
   assign bus.out1       = dout[1];
   assign bus.out1_valid = vld[1];
   assign bus.cnt0       = cnt[0];
   assign bus.cnt1       = cnt[1];
   assign bus.ptr        = ptr;
endmodule

// File: tb/tb_demux1to2_reg.sv
// Bench for demux1to2_reg: directed table, hand sequences (counter wrap,
// mid-stream reset) and randomized traffic against a behavioural model.
module tb_demux1to2_reg;
   logic clk;
   logic rst;

   demux1to2_reg_if #(.WIDTH(8)) bus ();

   demux1to2_reg #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: per channel a word slot (occupied flag + last data),
   // a delivery count, and the round-robin pointer.
   bit         m_known = 0;
   bit         m_vld [2];
   logic [7:0] m_dat [2];
   int         m_cnt [2];
   int         m_ptr;
   logic       ir_seen;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       s, a, r0, r1;
      logic       ir;
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic [7:0] c0, c1;
      logic       p;
   } vec_t;

   vec_t vt [19];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                        input logic s, input logic a, input logic r0, input logic r1);
      rst            = r;
      bus.in_valid   = iv;
      bus.in         = d;
      bus.sel        = s;
      bus.auto       = a;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic tick(input string tag);
      int         d;
      bit         acc, drn;
      bit         c_rst, c_iv, c_auto;
      bit         r [2];
      logic [7:0] c_in;
      #3;
      c_rst  = rst;
      c_iv   = bus.in_valid;
      c_auto = bus.auto;
      c_in   = bus.in;
      r[0]   = bus.out0_ready;
      r[1]   = bus.out1_ready;
      d      = c_auto ? m_ptr : int'(bus.sel);
      acc    = c_iv && (!m_vld[d] || r[d]);
      ir_seen = bus.in_ready;
      if (m_known)
         check({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, !m_vld[d] || r[d]});
      @(posedge clk);
      if (c_rst) begin
         m_vld[0] = 0; m_vld[1] = 0;
         m_dat[0] = 0; m_dat[1] = 0;
         m_cnt[0] = 0; m_cnt[1] = 0;
         m_ptr    = 0;
         m_known  = 1;
      end else begin
         for (int n = 0; n < 2; n++) begin
            drn = m_vld[n] && r[n];
            if (drn) m_cnt[n] = (m_cnt[n] + 1) % 256;
            if (acc && d == n) begin
               m_vld[n] = 1;
               m_dat[n] = c_in;
            end else if (drn) begin
               m_vld[n] = 0;
            end
         end
         if (acc && c_auto) m_ptr = 1 - m_ptr;
      end
      #1;
      if (m_known) begin
         check({tag, ".out0_valid"}, {31'd0, bus.out0_valid}, {31'd0, m_vld[0]});
         check({tag, ".out1_valid"}, {31'd0, bus.out1_valid}, {31'd0, m_vld[1]});
         check({tag, ".out0"},       {24'd0, bus.out0},       {24'd0, m_dat[0]});
         check({tag, ".out1"},       {24'd0, bus.out1},       {24'd0, m_dat[1]});
         check({tag, ".cnt0"},       {24'd0, bus.cnt0},       m_cnt[0]);
         check({tag, ".cnt1"},       {24'd0, bus.cnt1},       m_cnt[1]);
         check({tag, ".ptr"},        {31'd0, bus.ptr},        m_ptr);
      end
   endtask

   initial begin
      int guard;

      //          iv  d      s  a  r0 r1 | ir v0 d0     v1 d1     c0 c1 p
      vt[0]  = '{1, 8'h5A, 1, 0, 0, 1,   1, 0, 8'h00, 1, 8'h5A, 0, 0, 0};
      vt[1]  = '{0, 8'h00, 1, 0, 0, 1,   1, 0, 8'h00, 0, 8'h5A, 0, 1, 0};
      vt[2]  = '{1, 8'h01, 0, 1, 1, 1,   1, 1, 8'h01, 0, 8'h5A, 0, 1, 1};
      vt[3]  = '{1, 8'h02, 0, 1, 1, 1,   1, 0, 8'h01, 1, 8'h02, 1, 1, 0};
      vt[4]  = '{1, 8'h03, 0, 1, 1, 1,   1, 1, 8'h03, 0, 8'h02, 1, 2, 1};
      vt[5]  = '{1, 8'h04, 0, 1, 1, 1,   1, 0, 8'h03, 1, 8'h04, 2, 2, 0};
      vt[6]  = '{0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h03, 0, 8'h04, 2, 3, 0};
      vt[7]  = '{1, 8'hAA, 0, 0, 0, 0,   1, 1, 8'hAA, 0, 8'h04, 2, 3, 0};
      vt[8]  = '{1, 8'hBB, 0, 0, 0, 0,   0, 1, 8'hAA, 0, 8'h04, 2, 3, 0};
      vt[9]  = '{1, 8'hBB, 1, 0, 0, 0,   1, 1, 8'hAA, 1, 8'hBB, 2, 3, 0};
      vt[10] = '{0, 8'h00, 0, 0, 1, 0,   1, 0, 8'hAA, 1, 8'hBB, 3, 3, 0};
      vt[11] = '{1, 8'h11, 0, 0, 0, 0,   1, 1, 8'h11, 1, 8'hBB, 3, 3, 0};
      vt[12] = '{1, 8'h33, 0, 0, 1, 1,   1, 1, 8'h33, 0, 8'hBB, 4, 4, 0};
      vt[13] = '{0, 8'h00, 1, 0, 1, 0,   1, 0, 8'h33, 0, 8'hBB, 5, 4, 0};
      vt[14] = '{1, 8'h77, 0, 1, 0, 0,   1, 1, 8'h77, 0, 8'hBB, 5, 4, 1};
      vt[15] = '{1, 8'h88, 0, 0, 0, 0,   0, 1, 8'h77, 0, 8'hBB, 5, 4, 1};
      vt[16] = '{1, 8'h99, 0, 1, 0, 0,   1, 1, 8'h77, 1, 8'h99, 5, 4, 0};
      vt[17] = '{1, 8'hAB, 0, 1, 0, 0,   0, 1, 8'h77, 1, 8'h99, 5, 4, 0};
      vt[18] = '{0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h77, 0, 8'h99, 6, 5, 0};

      // Reset, then idle
      drive(1, 1, 8'hFF, 0, 0, 0, 0);
      tick("rst0");
      tick("rst1");
      drive(0, 0, 8'h00, 0, 0, 0, 0);
      tick("idle");
      check("idle.in_ready_const", {31'd0, ir_seen},        32'd1);
      check("idle.v0_const",       {31'd0, bus.out0_valid}, 32'd0);
      check("idle.v1_const",       {31'd0, bus.out1_valid}, 32'd0);
      check("idle.cnt_const",      {16'd0, bus.cnt1, bus.cnt0}, 32'd0);
      check("idle.ptr_const",      {31'd0, bus.ptr},        32'd0);

      // Directed table
      for (int i = 0; i < 19; i++) begin
         drive(0, vt[i].iv, vt[i].d, vt[i].s, vt[i].a, vt[i].r0, vt[i].r1);
         tick($sformatf("vec%0d", i));
         check($sformatf("vec%0d.tbl_ir", i), {31'd0, ir_seen},        {31'd0, vt[i].ir});
         check($sformatf("vec%0d.tbl_v0", i), {31'd0, bus.out0_valid}, {31'd0, vt[i].v0});
         check($sformatf("vec%0d.tbl_d0", i), {24'd0, bus.out0},       {24'd0, vt[i].d0});
         check($sformatf("vec%0d.tbl_v1", i), {31'd0, bus.out1_valid}, {31'd0, vt[i].v1});
         check($sformatf("vec%0d.tbl_d1", i), {24'd0, bus.out1},       {24'd0, vt[i].d1});
         check($sformatf("vec%0d.tbl_c0", i), {24'd0, bus.cnt0},       {24'd0, vt[i].c0});
         check($sformatf("vec%0d.tbl_c1", i), {24'd0, bus.cnt1},       {24'd0, vt[i].c1});
         check($sformatf("vec%0d.tbl_p",  i), {31'd0, bus.ptr},        {31'd0, vt[i].p});
      end

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 59) == 0), 1'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
         tick("rnd");
      end

      // Counter wrap on channel 1: stream into ch1 until 255 delivered with a
      // word still pending, then one more delivery must read back 0.
      guard = 0;
      drive(0, 1, 8'h00, 1, 0, 0, 1);
      while (!(m_cnt[1] == 255 && m_vld[1]) && guard < 2000) begin
         bus.in = 8'(guard);
         tick("wrap");
         guard++;
      end
      check("wrap.budget", {31'd0, (guard < 2000)}, 32'd1);
      drive(0, 0, 8'h00, 1, 0, 0, 1);
      tick("wrap_last");
      check("wrap.cnt1_zero", {24'd0, bus.cnt1}, 32'd0);

      // Reset mid-stream with a word pending on channel 0
      drive(0, 1, 8'hC3, 0, 0, 0, 0);
      tick("pre_rst");
      check("pre_rst.v0", {31'd0, bus.out0_valid}, 32'd1);
      drive(1, 1, 8'h3C, 0, 1, 0, 0);
      tick("mid_rst");
      check("mid_rst.v0",   {31'd0, bus.out0_valid}, 32'd0);
      check("mid_rst.out0", {24'd0, bus.out0},       32'd0);
      check("mid_rst.cnts", {16'd0, bus.cnt1, bus.cnt0}, 32'd0);
      check("mid_rst.ptr",  {31'd0, bus.ptr},        32'd0);
      drive(0, 0, 8'h00, 0, 0, 0, 0);
      tick("post_rst");
      check("post_rst.in_ready", {31'd0, ir_seen}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
